// File: rtl/flag_shadow_stack.sv
// flag_shadow_stack: LIFO save/restore of the CPU status flags across
// (possibly nested) interrupts. A push captures FLG_IN on interrupt
// acknowledge; a pop reads the top entry into FLG_OUT and raises FLG_LD
// for exactly one cycle so the flag register reloads it like any other load.
// Optional feature: define FLAG_STACK_ERR_EN to build the sticky ERR flag
// (overflow, underflow, push/pop collision, request while busy).
module flag_shadow_stack #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] FLG_IN,
    input  logic             PUSH,
    input  logic             POP,
    output logic [WIDTH-1:0] FLG_OUT,
    output logic             FLG_LD,
    output logic             BUSY,
    output logic             FULL,
    output logic             EMPTY,
    output logic [CW-1:0]    COUNT,
    output logic             ERR
);

    typedef enum logic {
        IDLE    = 1'b0,
        RESTORE = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] flg_out_reg, flg_out_next;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             idle;
    logic             full;
    logic             empty;
    logic             push_acc;
    logic             pop_acc;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    // Status decoded purely from registers, never from the request inputs.
    assign idle  = (state_reg == IDLE);
    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);

    // Push has priority over pop; nothing is accepted while a restore is
    // being presented to the flag register.
    assign push_acc = idle && PUSH && !full;
    assign pop_acc  = idle && POP && !PUSH && !empty;

    // Top of stack is COUNT-1; the next free slot is COUNT. The write index
    // is only used when not full, so truncation at COUNT==DEPTH is harmless.
    assign wr_idx = AW'(count_reg);
    assign rd_idx = AW'(count_reg - 1'b1);

    // Next-state, pointer and restore-data logic.
    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        flg_out_next = flg_out_reg;
        case (state_reg)
            IDLE: begin
                if (push_acc) begin
                    count_next = count_reg + 1'b1;
                end else if (pop_acc) begin
                    count_next   = count_reg - 1'b1;
                    flg_out_next = mem[rd_idx];
                    state_next   = RESTORE;
                end
            end
            RESTORE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, pointer and output-data registers; reset abandons any pending load.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            flg_out_reg <= '0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            flg_out_reg <= flg_out_next;
        end
    end

    // Entry storage: not reset, popped slots are left stale and simply reused.
    always_ff @(posedge CLK) begin
        if (push_acc && !RST) begin
            mem[wr_idx] <= FLG_IN;
        end
    end

`ifdef FLAG_STACK_ERR_EN
    logic err_reg;
    logic err_event;

    assign err_event = (idle && PUSH && full)
                     || (idle && POP && !PUSH && empty)
                     || (idle && PUSH && POP)
                     || (!idle && (PUSH || POP));

    // Sticky protocol-violation flag, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            err_reg <= 1'b0;
        end else if (err_event) begin
            err_reg <= 1'b1;
        end
    end

    assign ERR = err_reg;
`else
    assign ERR = 1'b0;
`endif

    assign FLG_OUT = flg_out_reg;
    assign FLG_LD  = (state_reg == RESTORE);
    assign BUSY    = (state_reg == RESTORE);
    assign FULL    = full;
    assign EMPTY   = empty;
    assign COUNT   = count_reg;

endmodule

// File: doc/flag_shadow_stack.md
# flag_shadow_stack

Interrupt-context save/restore for the CPU status flags (C, Z). Captures the flag register's current value on interrupt acknowledge and returns it to the flag register on return-from-interrupt. Drives the flag register's DIN/LD pins directly, so a restore lands exactly as a normal flag load would. It is a LIFO of configurable depth, so nested interrupts each restore their own context.

## Interface
- WIDTH, 2, number of flag bits saved per entry
- DEPTH, 4, number of stack entries (nesting levels); ≥ 2

- CLK  in  1  system clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- FLG_IN  in  WIDTH  current flag register output (value to save)
- PUSH  in  1  interrupt acknowledge: save FLG_IN this edge
- POP  in  1  return-from-interrupt: restore most recent entry
- FLG_OUT  out  WIDTH  restored flags, wired to flag register DIN
- FLG_LD  out  1  one-cycle load strobe, wired to flag register LD
- BUSY  out  1  restore in progress; requests ignored
- FULL  out  1  COUNT == DEPTH
- EMPTY  out  1  COUNT == 0
- COUNT  out  $clog2(DEPTH+1)  occupied entries
- ERR  out  1  sticky protocol error (see Configuration)

## Operation
- Storage: DEPTH×WIDTH register array plus pointer COUNT; top entry = index COUNT-1.
- FSM states: IDLE, RESTORE.
- IDLE, PUSH=1, not FULL: mem[COUNT] <= FLG_IN, COUNT+1; stay IDLE.
- IDLE, PUSH=1, FULL: no write, COUNT unchanged (overflow).
- IDLE, POP=1 (PUSH=0), not EMPTY: FLG_OUT <= mem[COUNT-1], COUNT-1, go RESTORE.
- IDLE, POP=1, EMPTY: no change, FLG_OUT holds, stay IDLE (underflow).
- PUSH and POP same edge in IDLE: PUSH wins (handled as above), POP dropped (collision).
- RESTORE: FLG_LD=1, BUSY=1; PUSH/POP ignored (busy-drop); unconditional return to IDLE next edge.
- FLG_LD = (state == RESTORE); combinational from state register, exactly one cycle per accepted POP.
- FLG_OUT holds last restored value indefinitely; meaningful to the flag register only while FLG_LD=1.
- Entries above COUNT are stale, never read; no clearing on pop.
- FULL, EMPTY, BUSY decoded from registers, no combinational path from inputs.

## Timing
- Reset (RST=1 at edge): state IDLE, COUNT=0, FLG_OUT=0, ERR=0; hence FLG_LD=0, BUSY=0, EMPTY=1, FULL=0. Memory contents not reset.
- RST mid-RESTORE: next cycle IDLE, FLG_LD=0; the pending load is abandoned.
- Push: FLG_IN sampled at edge k; COUNT/FULL updated after edge k.
- Pop: sampled at edge k; FLG_OUT and COUNT updated after k; FLG_LD high in cycle k→k+1; flag register captures at edge k+1. Earliest next accepted request: edge k+2.
- Back-to-back PUSH every cycle supported; POP throughput one per 2 cycles.
- Push-after-pop reuse: popped slot overwritten by next PUSH.

## Configuration
- Macro FLAG_STACK_ERR_EN.
- Defined: ERR set (sticky until RST) on overflow, underflow, PUSH/POP collision, or any PUSH/POP seen while BUSY. Storage behaviour identical to undefined case.
- Undefined: ERR tied 0, no error logic; violating requests are silently dropped as in Operation.

## Test plan
- Reset then idle: after RST, COUNT=0, EMPTY=1, FLG_LD=0, FLG_OUT=0, ERR=0.
- PUSH FLG_IN=2'b01 then 2'b10 (DEPTH=4) -> COUNT=2; POP -> next cycle FLG_OUT=2'b10, FLG_LD=1 one cycle, COUNT=1; POP again -> FLG_OUT=2'b01, COUNT=0, EMPTY=1.
- Push 4 entries 0,1,2,3 -> FULL=1; fifth PUSH 2'b11 -> COUNT stays 4, top still 3, ERR=1 with FLAG_STACK_ERR_EN, 0 without.
- POP on EMPTY -> no FLG_LD, FLG_OUT unchanged, COUNT=0, ERR=1 (macro on); simultaneous PUSH=POP=1 with COUNT=1 -> COUNT=2, no FLG_LD, ERR=1.
- POP then PUSH in the RESTORE cycle -> PUSH ignored, COUNT reflects only the pop, FLG_LD pulse width exactly 1.
- POP accepted, RST asserted next edge -> FLG_LD low after that edge, COUNT=0, state IDLE.
